id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register plus EX operand resolution. Latches decoded fields from ID, forwards results from EX/MEM and
//  MEM/WB, and drives alu_op/alu_operand1/alu_operand2 straight into the ALU. Detects load-use hazards; stalls ID and
//  injects a bubble. Clock clk; reset rst is asynchronous and active-high.
// PARAMETERS
//  XLEN      32     datapath width
//  REG_AW    5      register index width
//  OPW       4      ALU op code width
// PORTS
//  clk            in   1      clock
//  rst            in   1      async active-high reset
//  flush          in   1      kill ID-stage instruction (branch/jump taken)
//  id_valid       in   1      ID holds a real instruction
//  id_pc          in   XLEN   PC of ID instruction
//  id_rs1/id_rs2  in   REG_AW source register indices
//  id_rd          in   REG_AW destination index
//  id_rs1_data    in   XLEN   regfile read port 1
//  id_rs2_data    in   XLEN   regfile read port 2
//  id_imm         in   XLEN   sign-extended immediate
//  id_alu_op      in   OPW    ALU operation code
//  id_alu_src     in   1      1: operand2=imm, 0: operand2=rs2
//  id_op1_pc      in   1      1: operand1=pc (auipc/jal), 0: rs1
//  id_reg_write   in   1      writes rd
//  id_mem_read    in   1      load
//  id_mem_write   in   1      store
//  exm_reg_write  in   1      EX/MEM instruction writes rd
//  exm_rd         in   REG_AW EX/MEM destination
//  exm_result     in   XLEN   EX/MEM ALU result
//  wb_reg_write   in   1      MEM/WB instruction writes rd
//  wb_rd          in   REG_AW MEM/WB destination
//  wb_data        in   XLEN   MEM/WB writeback value
//  stall_id       out  1      hold PC and IF/ID register this cycle
//  ex_valid       out  1      EX holds a real instruction
//  ex_pc          out  XLEN   registered PC
//  alu_op         out  OPW    to ALU op
//  alu_operand1   out  XLEN   to ALU operand1 (forwarded)
//  alu_operand2   out  XLEN   to ALU operand2 (forwarded or imm)
//  ex_store_data  out  XLEN   forwarded rs2 value for stores
//  ex_rd          out  REG_AW registered rd
//  ex_reg_write / ex_mem_read / ex_mem_write  out 1  registered controls, forced 0 when !ex_valid
// BEHAVIOUR
//  - Reset: all registers 0; ex_valid=0, alu_op=0000 (add), outputs 0, stall_id=0.
//  - Per rising edge, priority: rst > flush > stall_id > capture.
//    flush: ex_valid<=0, controls<=0 (bubble); overrides a simultaneous stall.
//    stall_id: ex_valid<=0 (bubble); ID holds instruction, re-presented next cycle.
//    else: all id_* captured; ex_valid<=id_valid; controls gated by id_valid.
//  - Load-use: stall_id=id_valid & ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2); combinational, 1 cycle.
//  - Forwarding (per source, combinational off registered indices): x0 -> 0 always; else EX/MEM match with exm_reg_write
//    -> exm_result; else MEM/WB match with wb_reg_write -> wb_data; else registered regfile data. EX/MEM has priority.
//  - alu_operand1 = op1_pc ? ex_pc : fwd_rs1; alu_operand2 = alu_src ? imm : fwd_rs2; ex_store_data = fwd_rs2 always.
//  - Latency: ID inputs visible at ALU 1 cycle later; forward paths 0 cycles.
//  - Reset mid-stall: stall drops with ex_valid; no pending state survives.
// CONFIGURATION
//  - FWD_EN defined: forwarding as above; only load-use stalls.
//  - FWD_EN undefined: no forwarding muxes; operands use registered regfile data. stall_id asserts on any RAW (rd!=0)
//    against EX (ex_valid&ex_reg_write), EX/MEM (exm_reg_write) or MEM/WB (wb_reg_write) and holds until cleared.
// STRUCTURE
//  - Shared package riscv_pkg: XLEN, REG_AW, ALU op localparams (ALU_ADD=0000, SUB=0001, XOR=0010, OR=0011, AND=0100,
//    SLTU=0101, SLL=0110, SRL=0111, SRA=1000, SLT=1001), fwd_sel_t enum {FWD_RF, FWD_EXM, FWD_WB}.
//  - One sub-module ex_forward_mux, instanced twice (rs1, rs2): index, RF data, EX/MEM and MEM/WB tuples -> value.
// TESTING
//  - Reset: assert rst mid-capture -> ex_valid=0, alu_op=0000, all outputs 0 immediately (async).
//  - EX/MEM forward: exm_rd=5, exm_result=0x0000_00AA, ex rs1=5, rf data 0x11 -> alu_operand1=0xAA.
//  - Priority: exm_rd=wb_rd=7, exm_result=0x1, wb_data=0x2, rs2=7, alu_src=0 -> alu_operand2=0x1; rs=0 -> 0 regardless.
//  - Load-use: EX lw x3, ID add x4,x3,x3 -> stall_id=1 for 1 cycle, next ex_valid=0, then add issues with MEM/WB value.
//  - Flush+stall same cycle: flush=1, stall_id=1 -> ex_valid=0 next cycle, controls 0, no stall carried.
//  - FWD_EN undefined: exm_rd=9 writing, ID rs1=9 -> stall_id=1 until no stage writes x9; operand = regfile value.

Source files
------------

// File: rtl/riscv_pkg.sv
// ============================================================================
// Module : riscv_pkg
// Brief  : Shared datapath widths, ALU op codes, forwarding select encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int OPW    = 4;

    localparam logic [OPW-1:0] ALU_ADD  = 4'b0000;
    localparam logic [OPW-1:0] ALU_SUB  = 4'b0001;
    localparam logic [OPW-1:0] ALU_XOR  = 4'b0010;
    localparam logic [OPW-1:0] ALU_OR   = 4'b0011;
    localparam logic [OPW-1:0] ALU_AND  = 4'b0100;
    localparam logic [OPW-1:0] ALU_SLTU = 4'b0101;
    localparam logic [OPW-1:0] ALU_SLL  = 4'b0110;
    localparam logic [OPW-1:0] ALU_SRL  = 4'b0111;
    localparam logic [OPW-1:0] ALU_SRA  = 4'b1000;
    localparam logic [OPW-1:0] ALU_SLT  = 4'b1001;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EXM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    // True when a writer of rd (never x0) feeds either source of the reader.
    function automatic logic raw_hit(input logic we, input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2);
        return we && (rd != '0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_if.sv
// ============================================================================
// Module : id_ex_stage_if
// Brief  : ID/EX stage bus: ID fields, EX/MEM and MEM/WB bypass tuples, ALU side.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface id_ex_stage_if;
    import riscv_pkg::*;

    logic              flush;
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [XLEN-1:0]   id_imm;
    logic [OPW-1:0]    id_alu_op;
    logic              id_alu_src;
    logic              id_op1_pc;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;

    logic              exm_reg_write;
    logic [REG_AW-1:0] exm_rd;
    logic [XLEN-1:0]   exm_result;
    logic              wb_reg_write;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;

    logic              stall_id;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [OPW-1:0]    alu_op;
    logic [XLEN-1:0]   alu_operand1;
    logic [XLEN-1:0]   alu_operand2;
    logic [XLEN-1:0]   ex_store_data;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;

    modport master (
        output flush, id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
               id_imm, id_alu_op, id_alu_src, id_op1_pc, id_reg_write, id_mem_read,
               id_mem_write, exm_reg_write, exm_rd, exm_result, wb_reg_write, wb_rd, wb_data,
        input  stall_id, ex_valid, ex_pc, alu_op, alu_operand1, alu_operand2,
               ex_store_data, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
    );

    modport slave (
        input  flush, id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
               id_imm, id_alu_op, id_alu_src, id_op1_pc, id_reg_write, id_mem_read,
               id_mem_write, exm_reg_write, exm_rd, exm_result, wb_reg_write, wb_rd, wb_data,
        output stall_id, ex_valid, ex_pc, alu_op, alu_operand1, alu_operand2,
               ex_store_data, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
    );

endinterface

`default_nettype wire

// File: rtl/ex_forward_mux.sv
// ============================================================================
// Module : ex_forward_mux
// Brief  : Resolves one EX source operand from regfile, EX/MEM or MEM/WB.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_forward_mux
    import riscv_pkg::*;
(
    input  logic [REG_AW-1:0] i_rs,
    input  logic [XLEN-1:0]   i_rf_data,
    input  logic              i_exm_we,
    input  logic [REG_AW-1:0] i_exm_rd,
    input  logic [XLEN-1:0]   i_exm_data,
    input  logic              i_wb_we,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic [XLEN-1:0]   i_wb_data,
    output logic [XLEN-1:0]   o_value
);

    fwd_sel_t w_sel;

    // The younger producer (EX/MEM) wins over the older one.
    always_comb begin
        w_sel = FWD_RF;
        if (i_exm_we && (i_exm_rd == i_rs)) begin
            w_sel = FWD_EXM;
        end else if (i_wb_we && (i_wb_rd == i_rs)) begin
            w_sel = FWD_WB;
        end
    end

    always_comb begin
        o_value = i_rf_data;
        if (i_rs == '0) begin
            o_value = '0;
        end else begin
            case (w_sel)
                FWD_EXM: o_value = i_exm_data;
                FWD_WB:  o_value = i_wb_data;
                default: o_value = i_rf_data;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module : id_ex_stage
// Brief  : ID/EX pipeline register with operand forwarding and hazard stall.
//          Build option FWD_EN: enables bypass muxes (only load-use stalls).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_stage
    import riscv_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  bus
);

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [REG_AW-1:0] r_rs1;
    logic [REG_AW-1:0] r_rs2;
    logic [REG_AW-1:0] r_rd;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;
    logic [XLEN-1:0]   r_imm;
    logic [OPW-1:0]    r_alu_op;
    logic              r_alu_src;
    logic              r_op1_pc;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;

    logic              w_load_use;
    logic              w_stall;
    logic [XLEN-1:0]   w_fwd_rs1;
    logic [XLEN-1:0]   w_fwd_rs2;

    assign w_load_use = bus.id_valid & r_valid & r_mem_read
                      & raw_hit(1'b1, r_rd, bus.id_rs1, bus.id_rs2);

`ifdef FWD_EN
    assign w_stall = w_load_use;

    ex_forward_mux u_fwd_rs1 (
        .i_rs       (r_rs1),
        .i_rf_data  (r_rs1_data),
        .i_exm_we   (bus.exm_reg_write),
        .i_exm_rd   (bus.exm_rd),
        .i_exm_data (bus.exm_result),
        .i_wb_we    (bus.wb_reg_write),
        .i_wb_rd    (bus.wb_rd),
        .i_wb_data  (bus.wb_data),
        .o_value    (w_fwd_rs1)
    );

    ex_forward_mux u_fwd_rs2 (
        .i_rs       (r_rs2),
        .i_rf_data  (r_rs2_data),
        .i_exm_we   (bus.exm_reg_write),
        .i_exm_rd   (bus.exm_rd),
        .i_exm_data (bus.exm_result),
        .i_wb_we    (bus.wb_reg_write),
        .i_wb_rd    (bus.wb_rd),
        .i_wb_data  (bus.wb_data),
        .o_value    (w_fwd_rs2)
    );
`else
    // Without bypass, ID waits until every in-flight writer of its sources has retired.
    assign w_stall = w_load_use
                   | (bus.id_valid
                      & (raw_hit(r_valid & r_reg_write, r_rd, bus.id_rs1, bus.id_rs2)
                       | raw_hit(bus.exm_reg_write, bus.exm_rd, bus.id_rs1, bus.id_rs2)
                       | raw_hit(bus.wb_reg_write, bus.wb_rd, bus.id_rs1, bus.id_rs2)));

    assign w_fwd_rs1 = r_rs1_data;
    assign w_fwd_rs2 = r_rs2_data;

    logic w_unused;
    assign w_unused = ^{r_rs1, r_rs2, bus.exm_result, bus.wb_data};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
            r_alu_op    <= ALU_ADD;
            r_alu_src   <= 1'b0;
            r_op1_pc    <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (bus.flush || w_stall) begin
            // Bubble: data fields hold, only validity and side-effect controls drop.
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            r_valid     <= bus.id_valid;
            r_pc        <= bus.id_pc;
            r_rs1       <= bus.id_rs1;
            r_rs2       <= bus.id_rs2;
            r_rd        <= bus.id_rd;
            r_rs1_data  <= bus.id_rs1_data;
            r_rs2_data  <= bus.id_rs2_data;
            r_imm       <= bus.id_imm;
            r_alu_op    <= bus.id_alu_op;
            r_alu_src   <= bus.id_alu_src;
            r_op1_pc    <= bus.id_op1_pc;
            r_reg_write <= bus.id_reg_write & bus.id_valid;
            r_mem_read  <= bus.id_mem_read  & bus.id_valid;
            r_mem_write <= bus.id_mem_write & bus.id_valid;
        end
    end

    assign bus.stall_id      = w_stall;
    assign bus.ex_valid      = r_valid;
    assign bus.ex_pc         = r_pc;
    assign bus.alu_op        = r_alu_op;
    assign bus.alu_operand1  = r_op1_pc  ? r_pc  : w_fwd_rs1;
    assign bus.alu_operand2  = r_alu_src ? r_imm : w_fwd_rs2;
    assign bus.ex_store_data = w_fwd_rs2;
    assign bus.ex_rd         = r_rd;
    assign bus.ex_reg_write  = r_valid & r_reg_write;
    assign bus.ex_mem_read   = r_valid & r_mem_read;
    assign bus.ex_mem_write  = r_valid & r_mem_write;

endmodule

`default_nettype wire
